audio_mixer: RTL

- Sample-rate audio mixer that sits directly upstream of audio_out, in the clk_pixel domain.
- Combines three sources into the unsigned 16-bit core_l/core_r words that audio_out consumes:
  - SuperSprite audio (16-bit).
  - Mockingboard audio, left and right (10-bit each).
  - Apple speaker (1-bit).
- Applies a per-source gain, a mute/unmute envelope ramp driven by sleep, and output saturation with a sticky clip flag.
- Replaces the ad-hoc unsaturated adders feeding audio_out.

---
 rtl/audio_mixer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/audio_mixer.sv
// Three-source audio mixer with per-source gain, sleep-driven envelope ramp and saturating output.
// Optional build macro AUDIO_MIXER_MONO_EN folds left and right into one rounded mono mix.
module audio_mixer #(
    parameter int RAMP_STEP  = 1,
    parameter int GAIN_UNITY = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_stb_i,
    input  logic [15:0] ssp_audio_i,
    input  logic [9:0]  mb_audio_l_i,
    input  logic [9:0]  mb_audio_r_i,
    input  logic        speaker_i,
    input  logic        mute_i,
    input  logic        gain_wr_i,
    input  logic [1:0]  gain_sel_i,
    input  logic [7:0]  gain_data_i,
    output logic [15:0] core_l_o,
    output logic [15:0] core_r_o,
    output logic        valid_o,
    output logic        clip_o,
    input  logic        clip_clr_i,
    output logic [8:0]  env_o
);

    localparam logic [9:0] STEP    = 10'(RAMP_STEP);
    localparam logic [9:0] ENV_MAX = 10'd256;
    localparam logic [7:0] G_UNITY = 8'(GAIN_UNITY);

    logic [7:0]  r_gain_ssp;
    logic [7:0]  r_gain_mb;
    logic [7:0]  r_gain_spk;
    logic [8:0]  r_env;

    logic        r_v1;
    logic [16:0] r_ssp_s;
    logic [15:0] r_mbl_s;
    logic [15:0] r_mbr_s;
    logic [14:0] r_spk_s;
    logic [8:0]  r_env1;

    logic        r_v2;
    logic [18:0] r_sum_l;
    logic [18:0] r_sum_r;
    logic [8:0]  r_env2;

    logic [15:0] r_core_l;
    logic [15:0] r_core_r;
    logic        r_valid;
    logic        r_clip;

    logic [23:0] w_ssp_p;
    logic [22:0] w_mbl_p;
    logic [22:0] w_mbr_p;
    logic [21:0] w_spk_p;
    logic [16:0] w_ssp_s;
    logic [15:0] w_mbl_s;
    logic [15:0] w_mbr_s;
    logic [14:0] w_spk_s;
    logic [9:0]  w_env_up;
    logic [8:0]  w_env_next;
    logic [18:0] w_sum_l;
    logic [18:0] w_sum_r;
    logic [18:0] w_stage_l;
    logic [18:0] w_stage_r;
    logic [27:0] w_prod_l;
    logic [27:0] w_prod_r;
    logic [19:0] w_out_l;
    logic [19:0] w_out_r;
    logic        w_sat_l;
    logic        w_sat_r;
    logic [15:0] w_fin_l;
    logic [15:0] w_fin_r;
    logic        w_clip_set;

    // Scaling uses the gain registers as they stand at the strobe, so a coincident write lands one sample later.
    assign w_ssp_p = {8'b0, ssp_audio_i} * {16'b0, r_gain_ssp};
    assign w_mbl_p = {8'b0, mb_audio_l_i, 5'b0} * {15'b0, r_gain_mb};
    assign w_mbr_p = {8'b0, mb_audio_r_i, 5'b0} * {15'b0, r_gain_mb};
    assign w_spk_p = {8'b0, speaker_i, 13'b0} * {14'b0, r_gain_spk};
    assign w_ssp_s = 17'(w_ssp_p >> 7);
    assign w_mbl_s = 16'(w_mbl_p >> 7);
    assign w_mbr_s = 16'(w_mbr_p >> 7);
    assign w_spk_s = 15'(w_spk_p >> 7);

    assign w_env_up = {1'b0, r_env} + STEP;

    always_comb begin
        w_env_next = r_env;
        if (mute_i) begin
            if ({1'b0, r_env} > STEP) w_env_next = 9'({1'b0, r_env} - STEP);
            else                      w_env_next = '0;
        end else begin
            if (w_env_up >= ENV_MAX) w_env_next = 9'd256;
            else                     w_env_next = w_env_up[8:0];
        end
    end

    assign w_sum_l = {2'b0, r_ssp_s} + {3'b0, r_mbl_s} + {4'b0, r_spk_s};
    assign w_sum_r = {2'b0, r_ssp_s} + {3'b0, r_mbr_s} + {4'b0, r_spk_s};

`ifdef AUDIO_MIXER_MONO_EN
    logic [19:0] w_sum_m2;
    assign w_sum_m2  = {1'b0, w_sum_l} + {1'b0, w_sum_r} + 20'd1;
    assign w_stage_l = 19'(w_sum_m2 >> 1);
    assign w_stage_r = 19'(w_sum_m2 >> 1);
`else
    assign w_stage_l = w_sum_l;
    assign w_stage_r = w_sum_r;
`endif

    assign w_prod_l   = {9'b0, r_sum_l} * {19'b0, r_env2};
    assign w_prod_r   = {9'b0, r_sum_r} * {19'b0, r_env2};
    assign w_out_l    = 20'(w_prod_l >> 8);
    assign w_out_r    = 20'(w_prod_r >> 8);
    assign w_sat_l    = |w_out_l[19:16];
    assign w_sat_r    = |w_out_r[19:16];
    assign w_fin_l    = w_sat_l ? 16'hFFFF : w_out_l[15:0];
    assign w_fin_r    = w_sat_r ? 16'hFFFF : w_out_r[15:0];
    assign w_clip_set = r_v2 & (w_sat_l | w_sat_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gain_ssp <= G_UNITY;
            r_gain_mb  <= G_UNITY;
            r_gain_spk <= G_UNITY;
        end else if (gain_wr_i) begin
            case (gain_sel_i)
                2'd0:    r_gain_ssp <= gain_data_i;
                2'd1:    r_gain_mb  <= gain_data_i;
                2'd2:    r_gain_spk <= gain_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_env   <= '0;
            r_v1    <= 1'b0;
            r_ssp_s <= '0;
            r_mbl_s <= '0;
            r_mbr_s <= '0;
            r_spk_s <= '0;
            r_env1  <= '0;
        end else begin
            r_v1 <= sample_stb_i;
            if (sample_stb_i) begin
                r_env   <= w_env_next;
                r_env1  <= r_env;
                r_ssp_s <= w_ssp_s;
                r_mbl_s <= w_mbl_s;
                r_mbr_s <= w_mbr_s;
                r_spk_s <= w_spk_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_sum_l <= '0;
            r_sum_r <= '0;
            r_env2  <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sum_l <= w_stage_l;
                r_sum_r <= w_stage_r;
                r_env2  <= r_env1;
            end
        end
    end

    // Outputs hold between pulses; a new clip outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_l <= '0;
            r_core_r <= '0;
            r_valid  <= 1'b0;
            r_clip   <= 1'b0;
        end else begin
            r_valid <= r_v2;
            if (r_v2) begin
                r_core_l <= w_fin_l;
                r_core_r <= w_fin_r;
            end
            if (w_clip_set)      r_clip <= 1'b1;
            else if (clip_clr_i) r_clip <= 1'b0;
        end
    end

    assign core_l_o = r_core_l;
    assign core_r_o = r_core_r;
    assign valid_o  = r_valid;
    assign clip_o   = r_clip;
    assign env_o    = r_env;

endmodule
